// File: rtl/pipeline_qsq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_qsq_multiplier
// Description : Four-stage quarter-square multiplier, a*b = sq4(a+b) - sq4(a-b),
//               with valid/ready flow control and per-stage bubble collapsing.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_qsq_multiplier #(
  parameter int W     = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   product,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_signed
);

  localparam int SW    = W + 2;
  localparam int AW    = W + 1;
  localparam int PW    = 2 * W;
  localparam int DEPTH = 1 << AW;

  function automatic logic [PW-1:0] qsq_entry(input int n);
    longint sq;
    sq = longint'(n) * longint'(n);
    return PW'(sq >> 2);
  endfunction

  // Table of floor(n^2/4), built at elaboration; read through two registered ports.
  logic [PW-1:0] rom [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rom
      assign rom[gi] = qsq_entry(gi);
    end
  endgenerate

  logic             v1_q, v2_q, v3_q, v4_q;
  logic             v1_d, v2_d, v3_d, v4_d;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q, tag4_q;
  logic             sg1_q, sg2_q, sg3_q, sg4_q;
  logic [SW-1:0]    s1_q, d1_q;
  logic [AW-1:0]    sa2_q, da2_q;
  logic [PW-1:0]    q1_q, q2_q;
  logic [PW-1:0]    prod_q;

  logic             adv1, adv2, adv3, adv4;
  logic             ld1, ld2, ld3, ld4;
  logic [SW-1:0]    ext_a, ext_b;
  logic [SW-1:0]    s1_d, d1_d;
  logic [AW-1:0]    sa2_d, da2_d;
  logic [PW-1:0]    prod_d;

  // A stage may take new data when it is empty or its successor moves on.
  assign adv4     = !v4_q || out_ready;
  assign adv3     = !v3_q || adv4;
  assign adv2     = !v2_q || adv3;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  assign ld1 = adv1 && in_valid;
  assign ld2 = adv2 && v1_q;
  assign ld3 = adv3 && v2_q;
  assign ld4 = adv4 && v3_q;

  always_comb begin
    v1_d = adv1 ? in_valid : v1_q;
    v2_d = adv2 ? v1_q     : v2_q;
    v3_d = adv3 ? v2_q     : v3_q;
    v4_d = adv4 ? v3_q     : v4_q;
  end

  assign ext_a = in_signed ? {{2{A[W-1]}}, A} : {2'b00, A};
  assign ext_b = in_signed ? {{2{B[W-1]}}, B} : {2'b00, B};
  assign s1_d  = ext_a + ext_b;
  assign d1_d  = ext_a - ext_b;

  // Magnitudes never exceed 2^(W+1)-2 (unsigned) or 2^W (signed), so W+1 bits suffice.
  assign sa2_d  = s1_q[SW-1] ? AW'(-s1_q) : AW'(s1_q);
  assign da2_d  = d1_q[SW-1] ? AW'(-d1_q) : AW'(d1_q);
  assign prod_d = q1_q - q2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      v4_q <= v4_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_q <= '0;
      sg1_q  <= 1'b0;
      s1_q   <= '0;
      d1_q   <= '0;
    end else if (ld1) begin
      tag1_q <= in_tag;
      sg1_q  <= in_signed;
      s1_q   <= s1_d;
      d1_q   <= d1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag2_q <= '0;
      sg2_q  <= 1'b0;
      sa2_q  <= '0;
      da2_q  <= '0;
    end else if (ld2) begin
      tag2_q <= tag1_q;
      sg2_q  <= sg1_q;
      sa2_q  <= sa2_d;
      da2_q  <= da2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag3_q <= '0;
      sg3_q  <= 1'b0;
      q1_q   <= '0;
      q2_q   <= '0;
    end else if (ld3) begin
      tag3_q <= tag2_q;
      sg3_q  <= sg2_q;
      q1_q   <= rom[sa2_q];
      q2_q   <= rom[da2_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag4_q <= '0;
      sg4_q  <= 1'b0;
      prod_q <= '0;
    end else if (ld4) begin
      tag4_q <= tag3_q;
      sg4_q  <= sg3_q;
      prod_q <= prod_d;
    end
  end

  assign out_valid  = v4_q;
  assign product    = prod_q;
  assign out_tag    = tag4_q;
  assign out_signed = sg4_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_qsq_multiplier.sv
`default_nettype none
// Bench for pipeline_qsq_multiplier: directed vectors, flow-control sequences,
// random W=8 traffic and an exhaustive W=4 sweep against a reference multiply.
module tb_pipeline_qsq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // W=8 instance
  logic        iv8 = 0, is8 = 0, or8 = 1;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [3:0]  it8 = 0;
  logic        ir8, ov8, os8;
  logic [15:0] p8;
  logic [3:0]  ot8;

  // W=4 instance
  logic        iv4 = 0, is4 = 0, or4 = 1;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [3:0]  it4 = 0;
  logic        ir4, ov4, os4;
  logic [7:0]  p4;
  logic [3:0]  ot4;

  pipeline_qsq_multiplier #(.W(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_signed(is8),
    .A(a8), .B(b8), .in_tag(it8), .out_valid(ov8), .out_ready(or8),
    .product(p8), .out_tag(ot8), .out_signed(os8)
  );

  pipeline_qsq_multiplier #(.W(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_signed(is4),
    .A(a4), .B(b4), .in_tag(it4), .out_valid(ov4), .out_ready(or4),
    .product(p4), .out_tag(ot4), .out_signed(os4)
  );

  typedef struct {
    logic [15:0] prod;
    logic [3:0]  tag;
    logic        sgn;
  } exp_t;

  typedef struct {
    logic        sg;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  tag;
    logic [15:0] exp;
  } vec_t;

  exp_t q8[$];
  exp_t q4[$];
  int   oc8[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out8  = 0;
  int   n_out4  = 0;

  // Reference: interpret operands per mode and multiply with plain integers.
  function automatic longint mulref(input bit sg, input int w, input longint a, input longint b);
    longint x, y;
    x = a;
    y = b;
    if (sg && x[w-1]) x = x - (longint'(1) << w);
    if (sg && y[w-1]) y = y - (longint'(1) << w);
    return x * y;
  endfunction

  function automatic exp_t mk8(input bit sg, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] tag);
    exp_t   e;
    longint p;
    p      = mulref(sg, 8, longint'(a), longint'(b));
    e.prod = p[15:0];
    e.tag  = tag;
    e.sgn  = sg;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: record accepted inputs, compare each delivered product in order.
  always @(negedge clk) begin
    exp_t e;
    longint p;
    if (rst_n) begin
      if (iv8 && ir8) q8.push_back(mk8(is8, a8, b8, it8));
      if (ov8 && or8) begin
        n_tests++;
        n_out8++;
        oc8.push_back(cyc);
        if (q8.size() == 0) begin
          n_fail++;
          $display("FAIL out8_unexpected: got product 0x%0h tag 0x%0h, required no output", p8, ot8);
        end else begin
          e = q8.pop_front();
          if (p8 !== e.prod || ot8 !== e.tag || os8 !== e.sgn) begin
            n_fail++;
            $display("FAIL out8_item: got product 0x%0h tag 0x%0h sgn %0b, required 0x%0h tag 0x%0h sgn %0b",
                     p8, ot8, os8, e.prod, e.tag, e.sgn);
          end
        end
      end
      if (iv4 && ir4) begin
        p      = mulref(is4, 4, longint'(a4), longint'(b4));
        e.prod = {8'h00, p[7:0]};
        e.tag  = it4;
        e.sgn  = is4;
        q4.push_back(e);
      end
      if (ov4 && or4) begin
        n_tests++;
        n_out4++;
        if (q4.size() == 0) begin
          n_fail++;
          $display("FAIL out4_unexpected: got product 0x%0h, required no output", p4);
        end else begin
          e = q4.pop_front();
          if ({8'h00, p4} !== e.prod || ot4 !== e.tag || os4 !== e.sgn) begin
            n_fail++;
            $display("FAIL out4_item: got product 0x%0h tag 0x%0h, required 0x%0h tag 0x%0h",
                     p4, ot4, e.prod, e.tag);
          end
        end
      end
    end
  end

  // Send one vector into an empty pipeline and measure edges to out_valid,
  // counting the accepting edge as the first.
  task automatic send_check(input vec_t v);
    int edges;
    iv8 = 1'b1; is8 = v.sg; a8 = v.a; b8 = v.b; it8 = v.tag;
    @(negedge clk);
    chk("idle_in_ready", ir8, 1);
    tick();
    iv8   = 1'b0;
    edges = 1;
    while (!ov8 && edges < 20) begin
      tick();
      edges++;
    end
    chk("latency_edges", edges, 4);
    chk("vec_product", p8, v.exp);
    chk("vec_tag", ot8, v.tag);
    chk("vec_signed", os8, v.sg);
    tick();
  endtask

  task automatic wait_out8(input int target);
    int g;
    g = 0;
    while (n_out8 < target && g < 50) begin
      tick();
      g++;
    end
  endtask

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int   base, acc, stale, idx, guard, g;
    bit   took;
    logic [15:0] held;
    exp_t ex, ey;

    vecs[0] = '{1'b1, 8'h80, 8'h80, 4'h1, 16'h4000};
    vecs[1] = '{1'b1, 8'h80, 8'h7F, 4'h2, 16'hC080};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF, 4'h3, 16'hFE01};
    vecs[3] = '{1'b0, 8'h00, 8'hC3, 4'h4, 16'h0000};
    vecs[4] = '{1'b0, 8'h01, 8'hC3, 4'h5, 16'h00C3};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 4'h6, 16'h0001};
    vecs[6] = '{1'b1, 8'h7F, 8'h81, 4'h7, 16'hC0FF};
    vecs[7] = '{1'b0, 8'h80, 8'h02, 4'h8, 16'h0100};

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", ov8, 0);
    chk("rst_product", p8, 0);
    chk("rst_out_tag", ot8, 0);
    chk("rst_out_signed", os8, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", ir8, 1);
    tick();

    // Directed vectors
    for (int i = 0; i < 8; i++) send_check(vecs[i]);

    // Back-to-back stream, alternating modes
    repeat (3) tick();
    oc8.delete();
    base = n_out8;
    for (int i = 0; i < 16; i++) begin
      iv8 = 1'b1; is8 = i[0]; a8 = 8'($urandom); b8 = 8'($urandom); it8 = i[3:0];
      @(negedge clk);
      chk("stream_in_ready", ir8, 1);
      tick();
    end
    iv8 = 1'b0;
    wait_out8(base + 16);
    chk("stream_count", n_out8 - base, 16);
    if (oc8.size() >= 16) chk("stream_span", oc8[15] - oc8[0], 15);
    else chk("stream_outputs_seen", oc8.size(), 16);

    // Stall: out_ready low for 6 cycles with a persistent source
    repeat (3) tick();
    base = n_out8;
    or8 = 1'b0;
    acc = 0;
    held = '0;
    iv8 = 1'b1; is8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); it8 = 4'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      took = ir8;
      if (ir8) acc++;
      if (c == 4) begin
        chk("stall_out_valid", ov8, 1);
        held = p8;
      end
      if (c == 5) chk("stall_hold", p8, held);
      tick();
      if (took) begin
        is8 = ~is8; a8 = 8'($urandom); b8 = 8'($urandom); it8 = it8 + 4'h1;
      end
    end
    chk("stall_accepts", acc, 4);
    @(negedge clk);
    chk("stall_in_ready_low", ir8, 0);
    tick();
    iv8 = 1'b0;
    or8 = 1'b1;
    wait_out8(base + 4);
    repeat (3) tick();
    chk("stall_drain_count", n_out8 - base, 4);

    // Bubble collapse
    ex = mk8(1'b1, 8'h9C, 8'h37, 4'hA);
    ey = mk8(1'b0, 8'hE5, 8'hE5, 4'hB);
    or8 = 1'b0;
    iv8 = 1'b1; is8 = 1'b1; a8 = 8'h9C; b8 = 8'h37; it8 = 4'hA;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    iv8 = 1'b1; is8 = 1'b0; a8 = 8'hE5; b8 = 8'hE5; it8 = 4'hB;
    tick();
    iv8 = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("bubble_first_valid", ov8, 1);
    chk("bubble_first_product", p8, ex.prod);
    chk("bubble_in_ready", ir8, 1);
    tick();
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    @(negedge clk);
    chk("bubble_second_valid", ov8, 1);
    chk("bubble_second_product", p8, ey.prod);
    chk("bubble_second_tag", ot8, ey.tag);
    tick();
    or8 = 1'b1;
    repeat (3) tick();

    // Reset with three items in flight
    or8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv8 = 1'b1; is8 = 1'b0; a8 = 8'(i + 3); b8 = 8'h11; it8 = 4'(i);
      tick();
    end
    iv8 = 1'b0;
    tick();
    chk("pre_reset_valid", ov8, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ov8, 0);
    chk("async_rst_product", p8, 0);
    chk("async_rst_tag", ot8, 0);
    q8.delete();
    tick();
    rst_n = 1'b1;
    or8 = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov8) stale++;
      tick();
    end
    chk("post_reset_stale", stale, 0);
    send_check(vecs[1]);

    // Random traffic at W=8
    took = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!iv8 || took) begin
        iv8 = 1'($urandom_range(0, 1));
        is8 = 1'($urandom_range(0, 1));
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        it8 = 4'($urandom);
      end
      or8 = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = iv8 && ir8;
      tick();
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    repeat (10) tick();
    chk("random_drained", q8.size(), 0);

    // Exhaustive sweep at W=4
    idx = 0;
    guard = 0;
    iv4 = 1'b1; is4 = 1'b0; a4 = 4'h0; b4 = 4'h0; it4 = 4'h0;
    while (idx < 512 && guard < 5000) begin
      or4 = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = ir4;
      tick();
      guard++;
      if (took) begin
        idx++;
        if (idx < 512) begin
          is4 = idx[8]; a4 = idx[7:4]; b4 = idx[3:0]; it4 = idx[3:0];
        end else begin
          iv4 = 1'b0;
        end
      end
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    chk("sweep_all_sent", idx, 512);
    g = 0;
    while (q4.size() != 0 && g < 50) begin
      tick();
      g++;
    end
    chk("sweep_drained", q4.size(), 0);
    chk("sweep_count", n_out4, 512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
